// File: rtl/ser_pkg.sv
// Shared constants and types for the serial transmit scheduler.
package ser_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;

  typedef enum logic {
    ALIGN,
    RUN
  } tx_state_t;

endpackage

// File: rtl/ser_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr wins (wrapping).
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  localparam logic [IW:0] NW = (IW+1)'(N);

  logic [IW:0]   sum;
  logic [IW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    sum = '0;
    j   = '0;
    for (int i = 0; i < N; i++) begin
      // ptr < N, so one subtraction is enough to wrap
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= NW)
        sum = sum - NW;
      j = sum[IW-1:0];
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/ser_tx_scheduler.sv
// Lane scheduler ahead of the 8b/10b encoder: alignment, RR arbitration, commas.
// Define SER_TX_PKT_LOCK_EN to hold the grant until a packet's last character.
module ser_tx_scheduler
  import ser_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int ALIGN_CNT      = 16,
  parameter int COMMA_INTERVAL = 256,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_n,
  input  logic                          i_Slot,
  input  logic                          i_Retrain,
  input  logic [NUM_REQ-1:0]            i_Req_Valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_Req_Data,
  input  logic [NUM_REQ-1:0]            i_Req_K,
  input  logic [NUM_REQ-1:0]            i_Req_Last,
  output logic [NUM_REQ-1:0]            o_Req_Ready,
  output logic [DATA_WIDTH-1:0]         o_Tx_Data,
  output logic                          o_Tx_K,
  output logic [IW-1:0]                 o_Grant_Id,
  output logic                          o_Link_Up
);

  localparam int AW = $clog2(ALIGN_CNT + 1);
  localparam int CW = $clog2(COMMA_INTERVAL);

  localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_CNT - 1);
  localparam logic [CW-1:0] COMMA_LAST = CW'(COMMA_INTERVAL - 1);
  localparam logic [IW-1:0] PTR_LAST   = IW'(NUM_REQ - 1);

  tx_state_t     state;
  logic [AW-1:0] align_cnt;
  logic [CW-1:0] comma_cnt;
  logic [IW-1:0] rr_ptr;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;

  logic comma_due;
  logic send;
  logic idle;
  logic xfer;

  logic [DATA_WIDTH-1:0] data_sel;
  logic                  k_sel;
  logic                  last_sel;

`ifdef SER_TX_PKT_LOCK_EN
  logic          lock_vld;
  logic [IW-1:0] lock_id;

  always_comb begin
    elig = '0;
    if (lock_vld)
      elig[lock_id] = 1'b1;
    else
      elig = '1;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      lock_vld <= 1'b0;
      lock_id  <= '0;
    end else if (i_Retrain) begin
      lock_vld <= 1'b0;
    end else if (xfer) begin
      lock_vld <= ~last_sel;
      lock_id  <= gnt_idx;
    end
  end
`else
  logic unused_last;

  assign elig        = '1;
  assign unused_last = last_sel;
`endif

  assign req = i_Req_Valid & elig;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    data_sel = '0;
    k_sel    = 1'b0;
    last_sel = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (gnt[r]) begin
        data_sel = i_Req_Data[r*DATA_WIDTH +: DATA_WIDTH];
        k_sel    = i_Req_K[r];
        last_sel = i_Req_Last[r];
      end
    end
  end

  // the three RUN slot rules are made mutually exclusive here
  assign comma_due = (comma_cnt == COMMA_LAST);
  assign send      = ~comma_due & gnt_any;
  assign idle      = ~comma_due & ~gnt_any;

  assign xfer = i_Slot & ~i_Retrain & (state == RUN) & send;

  assign o_Req_Ready = xfer ? gnt : '0;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state      <= ALIGN;
      align_cnt  <= '0;
      comma_cnt  <= '0;
      rr_ptr     <= '0;
      o_Tx_Data  <= K28_5;
      o_Tx_K     <= 1'b1;
      o_Grant_Id <= '0;
      o_Link_Up  <= 1'b0;
    end else if (i_Retrain) begin
      state     <= ALIGN;
      align_cnt <= '0;
      comma_cnt <= '0;
      o_Link_Up <= 1'b0;
    end else if (i_Slot) begin
      unique case (state)
        ALIGN: begin
          o_Tx_Data <= K28_5;
          o_Tx_K    <= 1'b1;
          align_cnt <= align_cnt + AW'(1);
          if (align_cnt == ALIGN_LAST) begin
            state     <= RUN;
            o_Link_Up <= 1'b1;
          end
        end
        RUN: begin
          unique case (1'b1)
            comma_due: begin
              o_Tx_Data <= K28_5;
              o_Tx_K    <= 1'b1;
              comma_cnt <= '0;
            end
            send: begin
              o_Tx_Data  <= data_sel;
              o_Tx_K     <= k_sel;
              o_Grant_Id <= gnt_idx;
              rr_ptr     <= (gnt_idx == PTR_LAST) ? '0 : gnt_idx + IW'(1);
              comma_cnt  <= comma_cnt + CW'(1);
            end
            idle: begin
              o_Tx_Data <= K28_5;
              o_Tx_K    <= 1'b1;
              comma_cnt <= '0;
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser_tx_scheduler.sv
// Scoreboard bench for ser_tx_scheduler (NUM_REQ=4, ALIGN_CNT=16, COMMA_INTERVAL=8).
module tb_ser_tx_scheduler;

  localparam int NR = 4;
  localparam int AC = 16;
  localparam int CI = 8;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        slot    = 1'b0;
  logic        retrain = 1'b0;
  logic [3:0]  valid   = '0;
  logic [31:0] data    = '0;
  logic [3:0]  kf      = '0;
  logic [3:0]  last    = '0;

  logic [3:0] ready;
  logic [7:0] tx_data;
  logic       tx_k;
  logic [1:0] gid;
  logic       link;

  always #5 clk = ~clk;

  ser_tx_scheduler #(
    .NUM_REQ        (NR),
    .DATA_WIDTH     (8),
    .ALIGN_CNT      (AC),
    .COMMA_INTERVAL (CI)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_Slot      (slot),
    .i_Retrain   (retrain),
    .i_Req_Valid (valid),
    .i_Req_Data  (data),
    .i_Req_K     (kf),
    .i_Req_Last  (last),
    .o_Req_Ready (ready),
    .o_Tx_Data   (tx_data),
    .o_Tx_K      (tx_k),
    .o_Grant_Id  (gid),
    .o_Link_Up   (link)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic [1:0] g;
    logic       l;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  bit   m_run;
  bit   m_lock;
  int   m_align;
  int   m_comma;
  int   m_ptr;
  int   m_lock_id;
  exp_t m_out;

  function automatic exp_t cur();
    return {tx_data, tx_k, gid, link};
  endfunction

  task automatic model_reset();
    m_run   = 0;
    m_lock  = 0;
    m_align = 0;
    m_comma = 0;
    m_ptr   = 0;
    m_lock_id = 0;
    m_out   = {8'hBC, 1'b1, 2'd0, 1'b0};
    sb.delete();
  endtask

  task automatic model_retrain();
    m_run   = 0;
    m_align = 0;
    m_comma = 0;
    m_lock  = 0;
    m_out.l = 1'b0;
  endtask

  task automatic model_slot(input bit rt, output logic [3:0] rdy);
    int g;
    rdy = '0;
    g   = -1;
    if (rt) begin
      model_retrain();
    end else if (!m_run) begin
      m_out.d = 8'hBC;
      m_out.k = 1'b1;
      if (m_align == AC - 1) begin
        m_run   = 1;
        m_out.l = 1'b1;
      end
      m_align++;
    end else if (m_comma == CI - 1) begin
      m_out.d = 8'hBC;
      m_out.k = 1'b1;
      m_comma = 0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        int j;
        j = (m_ptr + i) % NR;
        if (g < 0 && valid[j] && (!m_lock || m_lock_id == j))
          g = j;
      end
      if (g < 0) begin
        m_out.d = 8'hBC;
        m_out.k = 1'b1;
        m_comma = 0;
      end else begin
        rdy[g]  = 1'b1;
        m_out.d = data[g*8 +: 8];
        m_out.k = kf[g];
        m_out.g = 2'(g);
        m_ptr   = (g + 1) % NR;
        m_comma++;
`ifdef SER_TX_PKT_LOCK_EN
        m_lock    = !last[g];
        m_lock_id = g;
`endif
      end
    end
    sb.push_back(m_out);
  endtask

  task automatic drive_slot(input bit rt, output logic [3:0] er,
                            output logic [3:0] ar);
    @(negedge clk);
    slot    = 1'b1;
    retrain = rt;
    #1;
    ar = ready;
    model_slot(rt, er);
    @(posedge clk);
    #1;
    slot    = 1'b0;
    retrain = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    e = {8'hBC, 1'b1, 2'd0, 1'b0};
    valid = '1;
    repeat (2) @(negedge clk);
    slot = 1'b1;
    #1;
    checks++;
    if (ready !== 4'b0) begin
      errors++;
      $display("FAIL reset_ready got %b exp 0000", ready);
    end
    checks++;
    if (cur() !== e) begin
      errors++;
      $display("FAIL reset_out got %h exp %h", cur(), e);
    end
    @(negedge clk);
    slot  = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_align();
    logic [3:0] er, ar;
    exp_t e;
    valid = '1;
    data  = 32'h4433_2211;
    for (int i = 0; i < AC; i++) begin
      drive_slot(0, er, ar);
      e = sb.pop_front();
      checks++;
      if (ar !== er || cur() !== e) begin
        errors++;
        $display("FAIL align%0d got %b/%h exp %b/%h", i, ar, cur(), er, e);
      end
      if (i < AC - 1)
        repeat (9) @(negedge clk);
    end
    checks++;
    if (link !== 1'b1) begin
      errors++;
      $display("FAIL align_linkup got %b exp 1", link);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] er, ar;
    exp_t e;
    int   seq [5] = '{0, 1, 2, 3, 0};
    valid = '1;
    kf    = '0;
    data  = 32'h1312_1110;
    for (int i = 0; i < 5; i++) begin
      drive_slot(0, er, ar);
      e = sb.pop_front();
      checks++;
      if (ar !== er || !$onehot(ar) || cur() !== e) begin
        errors++;
        $display("FAIL rr%0d got %b/%h exp %b/%h", i, ar, cur(), er, e);
      end
      checks++;
      if (gid !== 2'(seq[i]) || tx_data !== 8'(8'h10 + seq[i])) begin
        errors++;
        $display("FAIL rr_seq%0d got %0d/%h exp %0d", i, gid, tx_data, seq[i]);
      end
    end
  endtask

  task automatic test_single_req();
    logic [3:0] er, ar;
    exp_t e;
    valid = 4'b0100;
    data  = 32'h005A_0000;
    kf    = '0;
    for (int i = 0; i < 3; i++) begin
      drive_slot(0, er, ar);
      e = sb.pop_front();
      checks++;
      if (ar !== er || cur() !== e) begin
        errors++;
        $display("FAIL single%0d got %b/%h exp %b/%h", i, ar, cur(), er, e);
      end
      if (i == 0) begin
        checks++;
        if (tx_data !== 8'h5A || tx_k !== 1'b0 || gid !== 2'd2) begin
          errors++;
          $display("FAIL single_first got %h/%b/%0d exp 5a/0/2",
                   tx_data, tx_k, gid);
        end
      end
      repeat (3) begin
        @(negedge clk);
        #1;
        checks++;
        if (ready !== 4'b0 || cur() !== m_out) begin
          errors++;
          $display("FAIL single_gap got %b/%h exp 0000/%h", ready, cur(), m_out);
        end
      end
    end
  endtask

  task automatic test_comma();
    logic [3:0] er, ar;
    exp_t e;
    int   commas = 0;
    valid = 4'b0010;
    data  = 32'h0000_A100;
    kf    = '0;
    for (int i = 0; i < 3 * CI; i++) begin
      drive_slot(0, er, ar);
      e = sb.pop_front();
      checks++;
      if (ar !== er || cur() !== e) begin
        errors++;
        $display("FAIL comma%0d got %b/%h exp %b/%h", i, ar, cur(), er, e);
      end
      if (tx_k)
        commas++;
    end
    checks++;
    if (commas != 3) begin
      errors++;
      $display("FAIL comma_count got %0d exp 3", commas);
    end
  endtask

  task automatic test_idle();
    logic [3:0] er, ar;
    exp_t e;
    valid = '0;
    for (int i = 0; i < 2; i++) begin
      drive_slot(0, er, ar);
      e = sb.pop_front();
      checks++;
      if (ar !== er || cur() !== e) begin
        errors++;
        $display("FAIL idle%0d got %b/%h exp %b/%h", i, ar, cur(), er, e);
      end
    end
  endtask

  task automatic test_retrain();
    logic [3:0] er, ar;
    exp_t e;
    valid = '1;
    data  = 32'h2423_2221;
    @(negedge clk);
    retrain = 1'b1;
    #1;
    checks++;
    if (ready !== 4'b0) begin
      errors++;
      $display("FAIL retrain_ready got %b exp 0000", ready);
    end
    model_retrain();
    @(posedge clk);
    #1;
    retrain = 1'b0;
    checks++;
    if (link !== 1'b0 || cur() !== m_out) begin
      errors++;
      $display("FAIL retrain_out got %h exp %h", cur(), m_out);
    end
    for (int i = 0; i < AC + 3; i++) begin
      drive_slot(0, er, ar);
      e = sb.pop_front();
      checks++;
      if (ar !== er || cur() !== e) begin
        errors++;
        $display("FAIL realign%0d got %b/%h exp %b/%h", i, ar, cur(), er, e);
      end
    end
    drive_slot(1, er, ar);
    e = sb.pop_front();
    checks++;
    if (ar !== 4'b0 || cur() !== e) begin
      errors++;
      $display("FAIL retrain_slot got %b/%h exp 0000/%h", ar, cur(), e);
    end
    for (int i = 0; i < AC; i++) begin
      drive_slot(0, er, ar);
      e = sb.pop_front();
      checks++;
      if (ar !== er || cur() !== e) begin
        errors++;
        $display("FAIL realign2_%0d got %b/%h exp %b/%h", i, ar, cur(), er, e);
      end
    end
  endtask

`ifdef SER_TX_PKT_LOCK_EN
  task automatic test_lock();
    logic [3:0] er, ar;
    exp_t e;
    int   pkt = 0;
    bit   gap = 0;
    bit   r1  = 0;
    kf   = '0;
    last = 4'b0010;
    for (int i = 0; i < 12; i++) begin
      data[7:0]  = 8'hD0 + 8'(pkt);
      data[15:8] = 8'hE0;
      last[0]    = (pkt == 2);
      valid[0]   = (pkt < 3) && !(pkt == 1 && !gap);
      if (pkt == 1)
        gap = 1;
      valid[1]   = (pkt >= 1) || r1;
      drive_slot(0, er, ar);
      e = sb.pop_front();
      checks++;
      if (ar !== er || cur() !== e) begin
        errors++;
        $display("FAIL lock%0d got %b/%h exp %b/%h", i, ar, cur(), er, e);
      end
      checks++;
      if (ar[1] && pkt > 0 && pkt < 3) begin
        errors++;
        $display("FAIL lock_break%0d got req1 grant exp req0 pkt=%0d", i, pkt);
      end
      if (ar[0])
        pkt++;
      if (ar[1])
        r1 = 1;
    end
    checks++;
    if (pkt != 3 || !r1) begin
      errors++;
      $display("FAIL lock_done got pkt=%0d r1=%0b exp 3/1", pkt, r1);
    end
    valid = '0;
    last  = '0;
  endtask
`endif

  task automatic test_async_reset();
    exp_t e;
    e = {8'hBC, 1'b1, 2'd0, 1'b0};
    valid = '1;
    @(negedge clk);
    slot = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 4'b0 || cur() !== e) begin
      errors++;
      $display("FAIL async_reset got %b/%h exp 0000/%h", ready, cur(), e);
    end
    @(negedge clk);
    slot  = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_align();
    test_round_robin();
    test_single_req();
    test_comma();
    test_idle();
    test_retrain();
`ifdef SER_TX_PKT_LOCK_EN
    test_lock();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
